// File: rtl/cache_cfg_pkg.sv
// rtl/cache_cfg_pkg.sv - shared L1 cache geometry, derived widths and refill FSM states
package cache_cfg_pkg;

  localparam int way             = 1;
  localparam int block_size_byte = 16;
  localparam int cache_size_byte = 32768;

  function automatic int calc_bo(input int bsb);
    return $clog2(bsb);
  endfunction

  function automatic int calc_sets(input int csb, input int bsb, input int w);
    return csb / (bsb * w);
  endfunction

  function automatic int calc_si(input int csb, input int bsb, input int w);
    return $clog2(calc_sets(csb, bsb, w));
  endfunction

  function automatic int calc_tw(input int csb, input int bsb, input int w);
    return 32 - calc_si(csb, bsb, w) - calc_bo(bsb);
  endfunction

  function automatic int calc_beats(input int bsb);
    return bsb / 4;
  endfunction

  localparam int BO      = calc_bo(block_size_byte);
  localparam int SETS    = calc_sets(cache_size_byte, block_size_byte, way);
  localparam int SI      = calc_si(cache_size_byte, block_size_byte, way);
  localparam int TW      = calc_tw(cache_size_byte, block_size_byte, way);
  localparam int BEATS   = calc_beats(block_size_byte);
  localparam int BLOCK_W = block_size_byte * 8;
  // A single-word block still needs a 1-bit counter so the port stays legal.
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } refill_state_e;

endpackage

// File: rtl/cache_refill_engine_if.sv
// rtl/cache_refill_engine_if.sv - miss request, memory read and cache fill signals of the refill engine
interface cache_refill_engine_if;
  import cache_cfg_pkg::*;

  logic               miss_valid;
  logic               miss_ready;
  logic [TW-1:0]      miss_tag;
  logic [SI-1:0]      miss_index;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [31:0]        mem_rdata;
  logic               fill_valid;
  logic [TW-1:0]      fill_tag;
  logic [SI-1:0]      fill_index;
  logic [BLOCK_W-1:0] fill_block;
  logic               busy;
  logic [15:0]        refill_count;

  modport master (
    input  miss_valid, miss_tag, miss_index, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_valid, fill_tag, fill_index,
           fill_block, busy, refill_count
  );

  modport slave (
    output miss_valid, miss_tag, miss_index, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_valid, fill_tag, fill_index,
           fill_block, busy, refill_count
  );

endinterface

// File: rtl/cache_refill_engine_beat.sv
// rtl/cache_refill_engine_beat.sv - beat counter and block register that assemble memory words into a cache block
module refill_beat_assembler
  import cache_cfg_pkg::*;
(
  input  logic               clk2,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [31:0]        data,
  output logic [BEAT_W-1:0]  beat,
  output logic               last_beat,
  output logic [BLOCK_W-1:0] block
);

  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BLOCK_W-1:0] block_q, block_d;

  always_comb begin
    beat_d  = beat_q;
    block_d = block_q;
    if (clear) begin
      beat_d  = '0;
      block_d = '0;
    end else if (load) begin
      // Beat 0 lands in the least-significant word of the block.
      block_d[32*beat_q +: 32] = data;
      beat_d                   = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      beat_q  <= '0;
      block_q <= '0;
    end else begin
      beat_q  <= beat_d;
      block_q <= block_d;
    end
  end

  assign beat      = beat_q;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign block     = block_q;

endmodule

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - fetches a missing block word by word and issues a one-cycle cache fill
module cache_refill_engine
  import cache_cfg_pkg::*;
(
  input  logic                  clk2,
  input  logic                  reset,
  cache_refill_engine_if.master bus
);

  refill_state_e      state_q, state_d;
  logic [TW-1:0]      tag_q, tag_d;
  logic [SI-1:0]      index_q, index_d;
  logic [15:0]        refill_count_q, refill_count_d;
  logic               asm_clear;
  logic               asm_load;
  logic               last_beat;
  logic [BEAT_W-1:0]  beat;
  logic [BLOCK_W-1:0] block;
  logic [31:0]        line_addr;

  refill_beat_assembler u_beat (
    .clk2      (clk2),
    .reset     (reset),
    .clear     (asm_clear),
    .load      (asm_load),
    .data      (bus.mem_rdata),
    .beat      (beat),
    .last_beat (last_beat),
    .block     (block)
  );

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    index_d        = index_q;
    refill_count_d = refill_count_q;
    asm_clear      = 1'b0;
    asm_load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          tag_d     = bus.miss_tag;
          index_d   = bus.miss_index;
          asm_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          asm_load = 1'b1;
          if (last_beat) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (refill_count_q != 16'hFFFF) begin
          refill_count_d = refill_count_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q        <= IDLE;
      tag_q          <= '0;
      index_q        <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      index_q        <= index_d;
      refill_count_q <= refill_count_d;
    end
  end

  // Address is decoded from registered tag/index/beat, so it only moves after an ack.
  assign line_addr = {tag_q, index_q, {BO{1'b0}}} | (32'(beat) << 2);

  assign bus.miss_ready   = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.mem_req      = (state_q == FETCH);
  assign bus.mem_addr     = (state_q == FETCH) ? line_addr : 32'd0;
  assign bus.fill_valid   = (state_q == FILL);
  assign bus.fill_tag     = tag_q;
  assign bus.fill_index   = index_q;
  assign bus.fill_block   = block;
  assign bus.refill_count = refill_count_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - scoreboard bench for cache_refill_engine
module tb_cache_refill_engine;
  import cache_cfg_pkg::*;

  typedef struct {
    logic [TW-1:0]      tag;
    logic [SI-1:0]      index;
    logic [BLOCK_W-1:0] block;
    logic [15:0]        count;
    int                 fill_cyc;
  } fill_t;

  logic clk2  = 1'b0;
  logic reset = 1'b1;

  cache_refill_engine_if bus();

  cache_refill_engine dut (
    .clk2  (clk2),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk2 = ~clk2;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  fill_t         sb[$];
  logic [TW-1:0] cur_tag = '0;
  logic [SI-1:0] cur_index = '0;
  logic [31:0]   cur_base = '0;
  int            mbeat = 0;
  int            wait_cnt = 0;
  int            ack_delay = 0;
  bit            stray_ack = 1'b0;
  logic [15:0]   exp_count = 16'd0;
  logic [15:0]   last_cnt = 16'd0;
  bit            prev_fill = 1'b0;

  always @(posedge clk2) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [TW-1:0] t, input logic [SI-1:0] i, input int b);
    logic [31:0] a;
    a = 32'({t, i});
    a = a << BO;
    a = a | (32'(b) << 2);
    return a;
  endfunction

  // Memory model: answers after ack_delay wait cycles and checks the address every requested cycle.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk2);
      if (bus.mem_req && !reset) begin
        check("mem_addr", 128'(bus.mem_addr), 128'(exp_addr(cur_tag, cur_index, mbeat)));
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur_base + 32'(mbeat);
          wait_cnt      = 0;
          mbeat++;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack   = stray_ack;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Fill monitor: pops the scoreboard on every strobe and checks strobe width and count afterwards.
  initial begin
    fill_t it;
    forever begin
      @(negedge clk2);
      if (prev_fill && !reset) begin
        check("fill_width", 128'(bus.fill_valid), 128'(0));
        check("refill_count", 128'(bus.refill_count), 128'(last_cnt));
      end
      prev_fill = 1'b0;
      if (bus.fill_valid && !reset) begin
        if (sb.size() == 0) begin
          check("fill_unexpected", 128'(1), 128'(0));
        end else begin
          it = sb.pop_front();
          check("fill_tag", 128'(bus.fill_tag), 128'(it.tag));
          check("fill_index", 128'(bus.fill_index), 128'(it.index));
          check("fill_block", bus.fill_block, it.block);
          check("fill_cycle", 128'(cyc), 128'(it.fill_cyc));
          last_cnt  = it.count;
          prev_fill = 1'b1;
        end
      end
    end
  end

  task automatic do_miss(input logic [TW-1:0] t, input logic [SI-1:0] i, input logic [31:0] base, input int delay);
    fill_t it;
    int    guard = 0;
    @(negedge clk2);
    while (!bus.miss_ready && guard < 200) begin
      @(negedge clk2);
      guard++;
    end
    if (!bus.miss_ready) begin
      check("miss_ready_timeout", 128'(0), 128'(1));
      return;
    end
    bus.miss_valid = 1'b1;
    bus.miss_tag   = t;
    bus.miss_index = i;
    cur_tag   = t;
    cur_index = i;
    cur_base  = base;
    mbeat     = 0;
    wait_cnt  = 0;
    ack_delay = delay;
    it.tag    = t;
    it.index  = i;
    it.block  = '0;
    for (int b = 0; b < BEATS; b++) it.block[32*b +: 32] = base + 32'(b);
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    it.count    = exp_count;
    it.fill_cyc = cyc + BEATS * (delay + 1) + 1;
    sb.push_back(it);
    @(negedge clk2);
    bus.miss_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || bus.busy) && g < 1000) begin
      @(negedge clk2);
      g++;
    end
    if (g >= 1000) check("drain_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int g;
    bus.miss_valid = 1'b0;
    bus.miss_tag   = '0;
    bus.miss_index = '0;
    repeat (2) @(negedge clk2);
    check("rst_miss_ready_in_reset", 128'(bus.miss_ready), 128'(1));
    reset = 1'b0;
    @(negedge clk2);
    check("rst_miss_ready", 128'(bus.miss_ready), 128'(1));
    check("rst_mem_req", 128'(bus.mem_req), 128'(0));
    check("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_fill_valid", 128'(bus.fill_valid), 128'(0));
    check("rst_fill_block", bus.fill_block, 128'(0));
    check("rst_refill_count", 128'(bus.refill_count), 128'(0));

    // Directed miss with ack every cycle; also pins the absolute first address.
    do_miss(17'h1ABCD, 11'h123, 32'd1, 0);
    check("first_addr", 128'(bus.mem_addr), 128'h0000_0000_0000_0000_0000_0000_D5E6_9230);
    drain();
    check("first_block_const", bus.fill_block, 128'h00000004_00000003_00000002_00000001);
    check("first_count", 128'(bus.refill_count), 128'(1));

    // Same miss with three wait cycles per beat, plus miss_valid pulsed during FETCH.
    do_miss(17'h1ABCD, 11'h123, 32'd1, 3);
    repeat (4) begin
      @(negedge clk2);
      bus.miss_valid = 1'b1;
      bus.miss_tag   = 17'h0F0F0;
      bus.miss_index = 11'h555;
      check("busy_miss_ready", 128'(bus.miss_ready), 128'(0));
    end
    bus.miss_valid = 1'b0;
    drain();
    check("delayed_block_const", bus.fill_block, 128'h00000004_00000003_00000002_00000001);

    // Random misses, back to back, with stray acks outside FETCH.
    stray_ack = 1'b1;
    for (int n = 0; n < 10; n++) begin
      do_miss(TW'($urandom), SI'($urandom), $urandom, int'($urandom_range(0, 2)));
    end
    drain();
    stray_ack = 1'b0;

    // Reset during the third beat aborts the refill.
    do_miss(17'h00A5A, 11'h7FF, 32'h1000_0000, 3);
    g = 0;
    while (mbeat < 2 && g < 100) begin
      @(negedge clk2);
      g++;
    end
    if (mbeat < 2) check("third_beat_timeout", 128'(0), 128'(1));
    reset = 1'b1;
    sb.delete();
    exp_count = 16'd0;
    @(negedge clk2);
    reset = 1'b0;
    check("abort_miss_ready", 128'(bus.miss_ready), 128'(1));
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_mem_req", 128'(bus.mem_req), 128'(0));
    check("abort_fill_valid", 128'(bus.fill_valid), 128'(0));
    check("abort_refill_count", 128'(bus.refill_count), 128'(0));
    repeat (20) @(negedge clk2);

    // Saturation: preload the counter near the top, then run back-to-back misses.
    force dut.refill_count_q = 16'hFFFC;
    @(negedge clk2);
    release dut.refill_count_q;
    exp_count = 16'hFFFC;
    @(negedge clk2);
    check("preload_count", 128'(bus.refill_count), 128'(16'hFFFC));
    for (int n = 0; n < 6; n++) begin
      do_miss(TW'(n + 3), SI'(n * 7), 32'hA000_0000 + 32'(n << 8), 0);
    end
    drain();
    repeat (2) @(negedge clk2);
    check("saturated_count", 128'(bus.refill_count), 128'(16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
